// File: rtl/parc_mem_arb_pkg.sv
// Shared memory-arbiter definitions: source tags and PARC memory message layouts.
// Latency: n/a; backpressure: n/a.
package parc_mem_arb_pkg;

  localparam logic PARC_MEM_ARB_SRC_IMEM = 1'b0;
  localparam logic PARC_MEM_ARB_SRC_DMEM = 1'b1;

  localparam int unsigned MEM_TYPE_NBITS = 1;
  localparam int unsigned MEM_LEN_NBITS  = 2;

  // Request message: {type, addr, len, data}; response message: {type, len, data}.
  function automatic int unsigned mem_req_msg_sz(input int unsigned addr_nbits,
                                                 input int unsigned data_nbits);
    return MEM_TYPE_NBITS + addr_nbits + MEM_LEN_NBITS + data_nbits;
  endfunction

  function automatic int unsigned mem_resp_msg_sz(input int unsigned data_nbits);
    return MEM_TYPE_NBITS + MEM_LEN_NBITS + data_nbits;
  endfunction

  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

endpackage

// File: rtl/parc_mem_arb_tag_queue.sv
// In-order 1-bit source-tag FIFO of parameterised depth; push and pop may share a cycle.
// Latency: head visible the cycle after push; backpressure: push ignored when full, pop when empty.
module parc_mem_arb_tag_queue #(
  parameter int unsigned p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic empty,
  output logic full
);

  localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CNT_W = $clog2(p_depth + 1);

  logic [p_depth-1:0] tags;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(p_depth));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = tags[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) tags[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/parc_mem_arb.sv
// Round-robin 2:1 arbiter of PARCv2 imem/dmem onto one memory port, steering in-order responses back.
// Latency: zero-cycle request and response paths; backpressure: memreq_rdy and tag-queue full stall the granted port.
module parc_mem_arb
  import parc_mem_arb_pkg::*;
#(
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                                                clk,
  input  logic                                                reset,

  input  logic [mem_req_msg_sz(p_addr_nbits, p_data_nbits)-1:0] imemreq_msg,
  input  logic                                                imemreq_val,
  output logic                                                imemreq_rdy,
  output logic [mem_resp_msg_sz(p_data_nbits)-1:0]            imemresp_msg,
  output logic                                                imemresp_val,

  input  logic [mem_req_msg_sz(p_addr_nbits, p_data_nbits)-1:0] dmemreq_msg,
  input  logic                                                dmemreq_val,
  output logic                                                dmemreq_rdy,
  output logic [mem_resp_msg_sz(p_data_nbits)-1:0]            dmemresp_msg,
  output logic                                                dmemresp_val,

  output logic [mem_req_msg_sz(p_addr_nbits, p_data_nbits)-1:0] memreq_msg,
  output logic                                                memreq_val,
  input  logic                                                memreq_rdy,
  input  logic [mem_resp_msg_sz(p_data_nbits)-1:0]            memresp_msg,
  input  logic                                                memresp_val,

  output logic                                                resp_err
);

  logic prio;
  logic grant_imem;
  logic grant_dmem;
  logic fire;
  logic resp_hit;
  logic q_head_tag;
  logic q_empty;
  logic q_full;

  // Request side: prio only breaks ties, so a lone valid port always wins.
  always_comb begin
    grant_dmem  = dmemreq_val & (~imemreq_val | prio);
    grant_imem  = imemreq_val & (~dmemreq_val | ~prio);
    memreq_val  = (imemreq_val | dmemreq_val) & ~q_full & ~reset;
    memreq_msg  = grant_dmem ? dmemreq_msg : imemreq_msg;
    imemreq_rdy = grant_imem & memreq_rdy & ~q_full & ~reset;
    dmemreq_rdy = grant_dmem & memreq_rdy & ~q_full & ~reset;
    fire        = memreq_val & memreq_rdy;
  end

  // Response side: data fans out to both ports, only the valids are steered.
  always_comb begin
    resp_hit     = memresp_val & ~q_empty & ~reset;
    imemresp_msg = memresp_msg;
    dmemresp_msg = memresp_msg;
    imemresp_val = resp_hit & (q_head_tag == PARC_MEM_ARB_SRC_IMEM);
    dmemresp_val = resp_hit & (q_head_tag == PARC_MEM_ARB_SRC_DMEM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio     <= PARC_MEM_ARB_SRC_DMEM;
      resp_err <= 1'b0;
    end else begin
      if (fire)                   prio     <= ~grant_dmem;
      if (memresp_val && q_empty) resp_err <= 1'b1;
    end
  end

  parc_mem_arb_tag_queue #(
    .p_depth (p_max_inflight)
  ) u_tag_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (fire),
    .push_tag (grant_dmem ? PARC_MEM_ARB_SRC_DMEM : PARC_MEM_ARB_SRC_IMEM),
    .pop      (resp_hit),
    .head_tag (q_head_tag),
    .empty    (q_empty),
    .full     (q_full)
  );

endmodule

// File: tb/tb_parc_mem_arb.sv
// Directed bench for parc_mem_arb: arbitration order, backpressure, full stall, push/pop overlap, orphans.
module tb_parc_mem_arb;
  import parc_mem_arb_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  mem_req_t  imemreq_msg, dmemreq_msg, memreq_msg;
  mem_resp_t imemresp_msg, dmemresp_msg, memresp_msg;
  logic      imemreq_val, imemreq_rdy, imemresp_val;
  logic      dmemreq_val, dmemreq_rdy, dmemresp_val;
  logic      memreq_val, memreq_rdy, memresp_val, resp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parc_mem_arb #(
    .p_addr_nbits   (32),
    .p_data_nbits   (32),
    .p_max_inflight (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imemreq_msg  (imemreq_msg),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemresp_msg (imemresp_msg),
    .imemresp_val (imemresp_val),
    .dmemreq_msg  (dmemreq_msg),
    .dmemreq_val  (dmemreq_val),
    .dmemreq_rdy  (dmemreq_rdy),
    .dmemresp_msg (dmemresp_msg),
    .dmemresp_val (dmemresp_val),
    .memreq_msg   (memreq_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memresp_msg  (memresp_msg),
    .memresp_val  (memresp_val),
    .resp_err     (resp_err)
  );

  function automatic mem_req_t mk_req(input logic [31:0] addr, input logic [31:0] data);
    mem_req_t r;
    r.typ  = 1'b0;
    r.addr = addr;
    r.len  = 2'd0;
    r.data = data;
    return r;
  endfunction

  function automatic mem_resp_t mk_resp(input logic [31:0] data);
    mem_resp_t r;
    r.typ  = 1'b0;
    r.len  = 2'd0;
    r.data = data;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic iv, input mem_req_t im, input logic dv,
                           input mem_req_t dm, input logic rdy);
    imemreq_val = iv;
    imemreq_msg = im;
    dmemreq_val = dv;
    dmemreq_msg = dm;
    memreq_rdy  = rdy;
  endtask

  task automatic drive_resp(input logic v, input logic [31:0] data);
    memresp_val = v;
    memresp_msg = mk_resp(data);
  endtask

  initial begin
    // Reset with every input asserted: all outputs must stay quiet.
    reset = 1'b1;
    drive_req(1'b1, mk_req(32'h100, 32'h1), 1'b1, mk_req(32'h200, 32'h2), 1'b1);
    drive_resp(1'b1, 32'hEE);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_memreq_val",   memreq_val,   1'b0);
    chk("rst_imemreq_rdy",  imemreq_rdy,  1'b0);
    chk("rst_dmemreq_rdy",  dmemreq_rdy,  1'b0);
    chk("rst_imemresp_val", imemresp_val, 1'b0);
    chk("rst_dmemresp_val", dmemresp_val, 1'b0);
    chk("rst_resp_err",     resp_err,     1'b0);
    chk("rst_count",        dut.u_tag_queue.count, 3'd0);

    // Alternating: both ports valid, prio starts on dmem.
    @(negedge clk);
    reset = 1'b0;
    drive_req(1'b1, mk_req(32'h1000, 32'h10), 1'b1, mk_req(32'h2000, 32'hD0), 1'b1);
    drive_resp(1'b0, 32'h0);
    #1;
    chk("alt0_msg",  memreq_msg,  mk_req(32'h2000, 32'hD0));
    chk("alt0_val",  memreq_val,  1'b1);
    chk("alt0_drdy", dmemreq_rdy, 1'b1);
    chk("alt0_irdy", imemreq_rdy, 1'b0);
    @(negedge clk);
    drive_req(1'b1, mk_req(32'h1000, 32'h10), 1'b1, mk_req(32'h2004, 32'hD1), 1'b1);
    #1;
    chk("alt1_msg",  memreq_msg,  mk_req(32'h1000, 32'h10));
    chk("alt1_irdy", imemreq_rdy, 1'b1);
    chk("alt1_drdy", dmemreq_rdy, 1'b0);
    @(negedge clk);
    drive_req(1'b1, mk_req(32'h1004, 32'h11), 1'b1, mk_req(32'h2004, 32'hD1), 1'b1);
    drive_resp(1'b1, 32'hD0);
    #1;
    chk("alt2_msg",   memreq_msg,   mk_req(32'h2004, 32'hD1));
    chk("alt2_dval",  dmemresp_val, 1'b1);
    chk("alt2_ival",  imemresp_val, 1'b0);
    chk("alt2_dmsg",  dmemresp_msg, mk_resp(32'hD0));
    @(negedge clk);
    drive_req(1'b1, mk_req(32'h1004, 32'h11), 1'b1, mk_req(32'h2008, 32'hD2), 1'b1);
    drive_resp(1'b1, 32'h10);
    #1;
    chk("alt3_msg",  memreq_msg,   mk_req(32'h1004, 32'h11));
    chk("alt3_ival", imemresp_val, 1'b1);
    chk("alt3_dval", dmemresp_val, 1'b0);
    chk("alt3_imsg", imemresp_msg, mk_resp(32'h10));
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'hD1);
    #1;
    chk("alt4_reqval", memreq_val,   1'b0);
    chk("alt4_dval",   dmemresp_val, 1'b1);
    chk("alt4_dmsg",   dmemresp_msg, mk_resp(32'hD1));
    @(negedge clk);
    drive_resp(1'b1, 32'h11);
    #1;
    chk("alt5_ival", imemresp_val, 1'b1);
    chk("alt5_dval", dmemresp_val, 1'b0);
    @(negedge clk);
    drive_resp(1'b0, 32'h0);
    #1;
    chk("alt6_count", dut.u_tag_queue.count, 3'd0);

    // Backpressure: dmem alone, memory not ready for three cycles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b1, mk_req(32'h3000, 32'h55), 1'b0);
      #1;
      chk("bp_stall_val",  memreq_val,  1'b1);
      chk("bp_stall_drdy", dmemreq_rdy, 1'b0);
      chk("bp_stall_cnt",  dut.u_tag_queue.count, 3'd0);
    end
    @(negedge clk);
    memreq_rdy = 1'b1;
    #1;
    chk("bp_fire_drdy", dmemreq_rdy, 1'b1);
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'h55);
    #1;
    chk("bp_count1", dut.u_tag_queue.count, 3'd1);
    chk("bp_dval",   dmemresp_val, 1'b1);

    // Full: four imem requests fill the queue, the fifth stalls.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_req(1'b1, mk_req(32'h4000 + 32'(k * 4), 32'h40 + 32'(k)), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
      drive_resp(1'b0, 32'h0);
      #1;
      chk("full_fill_val",  memreq_val,  1'b1);
      chk("full_fill_irdy", imemreq_rdy, 1'b1);
    end
    @(negedge clk);
    drive_req(1'b1, mk_req(32'h4010, 32'h44), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'h20);
    #1;
    chk("full_5th_val",  memreq_val,   1'b0);
    chk("full_5th_irdy", imemreq_rdy,  1'b0);
    chk("full_count4",   dut.u_tag_queue.count, 3'd4);
    chk("full_ival",     imemresp_val, 1'b1);
    chk("full_dval",     dmemresp_val, 1'b0);
    @(negedge clk);
    drive_resp(1'b0, 32'h0);
    #1;
    chk("full_5th_fire", imemreq_rdy, 1'b1);
    chk("full_count3",   dut.u_tag_queue.count, 3'd3);
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'h21);
    #1;
    chk("full_refill4", dut.u_tag_queue.count, 3'd4);
    chk("full_ival2",   imemresp_val, 1'b1);
    @(negedge clk);
    drive_resp(1'b1, 32'h22);
    #1;
    chk("full_ival3", imemresp_val, 1'b1);

    // Simultaneous push and pop with two imem tags outstanding.
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b1, mk_req(32'h5000, 32'h77), 1'b1);
    drive_resp(1'b1, 32'h23);
    #1;
    chk("sim_count2", dut.u_tag_queue.count, 3'd2);
    chk("sim_ival",   imemresp_val, 1'b1);
    chk("sim_dval",   dmemresp_val, 1'b0);
    chk("sim_drdy",   dmemreq_rdy,  1'b1);
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'h24);
    #1;
    chk("sim_after_count", dut.u_tag_queue.count, 3'd2);
    chk("sim_head_ival",   imemresp_val, 1'b1);
    @(negedge clk);
    drive_resp(1'b1, 32'h77);
    #1;
    chk("sim_tail_dval", dmemresp_val, 1'b1);
    chk("sim_tail_ival", imemresp_val, 1'b0);
    @(negedge clk);
    drive_resp(1'b0, 32'h0);
    #1;
    chk("sim_drained", dut.u_tag_queue.count, 3'd0);

    // Reset with three requests outstanding, then an orphan response.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_req(1'b1, mk_req(32'h6000 + 32'(k * 4), 32'h60), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
      #1;
    end
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    reset = 1'b1;
    #1;
    chk("orph_pre_count", dut.u_tag_queue.count, 3'd3);
    chk("orph_pre_err",   resp_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_resp(1'b1, 32'h30);
    #1;
    chk("orph_count0", dut.u_tag_queue.count, 3'd0);
    chk("orph_ival",   imemresp_val, 1'b0);
    chk("orph_dval",   dmemresp_val, 1'b0);
    chk("orph_err0",   resp_err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_resp(1'b0, 32'h0);
      #1;
      chk("orph_err_sticky", resp_err, 1'b1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("orph_err_cleared", resp_err, 1'b0);

    // Zero-latency response to a request issued into an empty queue is an orphan.
    @(negedge clk);
    drive_req(1'b1, mk_req(32'h7000, 32'h70), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b1, 32'h70);
    #1;
    chk("zl_reqval", memreq_val,   1'b1);
    chk("zl_ival",   imemresp_val, 1'b0);
    chk("zl_dval",   dmemresp_val, 1'b0);
    @(negedge clk);
    drive_req(1'b0, mk_req(32'h0, 32'h0), 1'b0, mk_req(32'h0, 32'h0), 1'b1);
    drive_resp(1'b0, 32'h0);
    #1;
    chk("zl_err",   resp_err, 1'b1);
    chk("zl_count", dut.u_tag_queue.count, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
